npu_ofifo_collector: RTL and testbench
======================================

# npu_ofifo_collector

Drains the per-slice output FIFOs of the NPU matrix-vector slice array and serializes their results into one result stream toward the host/egress path. It is the reader end of the slice output-FIFO interface. It round-robin arbitrates among slices whose FIFO head is valid, pops one BATCH-wide entry, and emits its BATCH elements one per handshake, each tagged with the source slice and a last flag.

## Interface
- NUM_SLICES, `NUM_SLICES: number of slice output FIFOs drained.
- BATCH, `BATCH: elements per FIFO entry.
- ACCUM_DATAW, `ACCUM_DATAW: signed width of each FIFO element.
- RES_DATAW, `RES_DATAW: output element width when saturation is compiled in.
- SLICEW, $clog2(NUM_SLICES) (min 1): slice-tag width.
- OUTW, RES_DATAW if NPU_COLLECTOR_SAT_EN is defined, else ACCUM_DATAW.

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  reset; synchronous and active-high.
- i_ofifo_data  in  signed [ACCUM_DATAW-1:0] [0:NUM_SLICES-1][0:BATCH-1]  show-ahead head entry of each slice FIFO.
- i_ofifo_ready  in  1 [0:NUM_SLICES-1]  head entry valid (FIFO non-empty).
- o_ofifo_ren  out  1 [0:NUM_SLICES-1]  pop strobe. One-hot or all-zero.
- o_res_data  out  signed [OUTW-1:0]  result element.
- o_res_slice  out  [SLICEW-1:0]  source slice id.
- o_res_last  out  1  marks element BATCH-1 of the entry.
- o_res_valid  out  1  result valid.
- i_res_ready  in  1  downstream accepts.

## Operation
- The FSM has two states: ARB and SEND.
- **ARB:**
  - If any i_ofifo_ready[s] is high, the round-robin grant g asserts o_ofifo_ren[g] combinationally in the same cycle.
  - At that edge, i_ofifo_data[g] is captured into a BATCH-deep element buffer, slice tag g is registered, the element index is cleared to 0, the priority pointer moves to (g+1) mod NUM_SLICES, and the FSM goes to SEND.
  - If no slice is ready, the FSM stays in ARB with all ren low.
- **Priority:** search starts at the pointer and wraps; the pointer resets to 0.
- **SEND:**
  - o_res_valid=1; o_res_data = buffer[idx]; o_res_slice = tag; o_res_last = (idx==BATCH-1).
  - On valid&&ready with idx<BATCH-1: idx increments.
  - On valid&&ready with idx==BATCH-1: return to ARB.
  - With ready low: all outputs hold stable. Valid never drops without a handshake.
- o_ofifo_ren is never asserted in SEND and never while rst is high.
- BATCH=1: every element has last=1.
- Readiness of a slice that loses arbitration has no side effect; that slice is served in a later ARB cycle.

## Timing
- Reset values: o_ofifo_ren all 0, o_res_valid 0, o_res_data 0, o_res_slice 0, o_res_last 0, state ARB, pointer 0, idx 0.
- Reset mid-SEND discards the buffered entry. It is lost; no re-read occurs.
- Pop-to-first-output latency: ren asserted in cycle t, o_res_valid high in cycle t+1.
- With i_res_ready held high, one entry takes BATCH+1 cycles (BATCH SEND cycles plus one ARB cycle).
- Throughput is BATCH/(BATCH+1) elements/cycle.
- o_res_* are registered, except o_res_last, which is decoded from registered idx/state and is glitch-free at the clock edge.

## Configuration
- NPU_COLLECTOR_SAT_EN defined:
  - Each element is signed-saturated from ACCUM_DATAW to RES_DATAW at buffer capture.
  - Values > 2^(RES_DATAW-1)-1 clamp to the maximum; values < -2^(RES_DATAW-1) clamp to the minimum.
  - OUTW = RES_DATAW.
- NPU_COLLECTOR_SAT_EN undefined: elements pass unmodified; OUTW = ACCUM_DATAW.

## Structure
- NUM_SLICES, BATCH, ACCUM_DATAW and the new RES_DATAW come from the shared npu.vh defines; RES_DATAW is added there.
- The FSM state encoding (ARB, SEND) lives in a shared package, npu_pkg, next to the other NPU control enums.
- One sub-module: npu_rr_arbiter (NUM_SLICES requests, pointer input, one-hot grant plus index, combinational). It is reusable for instruction dispatch.
- The saturation function sits in npu_pkg.

## Test plan
- **Single slice, continuous ready:** NUM_SLICES=4, BATCH=3, slice 2 ready with {5,-7,9}, ready held high.
  - ren[2] for exactly 1 cycle.
  - Outputs 5, -7, 9 on 3 consecutive cycles with slice=2 and last only on 9.
  - Next ARB cycle has no ren.
- **Round-robin fairness:** all 4 slices continuously ready.
  - Grant order 0,1,2,3,0.
  - Each grant is exactly 4 cycles apart.
- **Backpressure:** i_res_ready low for 5 cycles mid-entry (at element 1).
  - data/slice/last/valid stable throughout.
  - No ren asserted.
  - Element 1 is not duplicated or skipped.
- **Reset mid-SEND:** rst pulsed high 1 cycle at idx=1.
  - Next cycle all outputs at reset values and pointer=0.
  - With slices 1 and 3 ready afterward, slice 1 is granted first.
- **Saturation** (NPU_COLLECTOR_SAT_EN, RES_DATAW=8): entry {300,-300,-128}.
  - Outputs 127, -128, -128.
  - Same entry without the macro outputs 300, -300, -128.
- **BATCH=1 build:** slices 0 and 1 alternate readiness.
  - Every output has last=1.
  - Ren and valid alternate 1-cycle apart.

Source files
------------

// File: rtl/npu_ofifo_collector_pkg.sv
// ----------------------------------------------------------------------------
// npu_ofifo_collector_pkg
// Shared types and helpers for the NPU output-FIFO collector:
//   coll_state_e : collector FSM state (ARB = pick a slice, SEND = stream entry)
//   sat_signed   : clamp a sign-extended value into a signed range of w bits
// ----------------------------------------------------------------------------
package npu_ofifo_collector_pkg;

  typedef enum logic {
    ARB  = 1'b0,
    SEND = 1'b1
  } coll_state_e;

  // v is sign-extended to 64 bits by the caller; the result is the nearest
  // value representable in w-bit two's complement, still sign-extended.
  function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                    input int unsigned       w);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

endpackage

// File: rtl/npu_ofifo_collector_if.sv
// ----------------------------------------------------------------------------
// npu_ofifo_collector_if
// Bundles the slice output-FIFO read side and the serialized result stream.
//   i_ofifo_data  : show-ahead head entry of each slice FIFO
//   i_ofifo_ready : per-slice head-valid (FIFO non-empty), bit s = slice s
//   o_ofifo_ren   : per-slice pop strobe, one-hot or zero
//   o_res_data    : result element (OUTW bits, signed)
//   o_res_slice   : source slice id
//   o_res_last    : last element of the entry
//   o_res_valid   : result valid
//   i_res_ready   : downstream accepts
// Modports: master = collector side, slave = FIFO array / downstream side.
// ----------------------------------------------------------------------------
interface npu_ofifo_collector_if #(
  parameter int unsigned NUM_SLICES  = 4,
  parameter int unsigned BATCH       = 3,
  parameter int unsigned ACCUM_DATAW = 16,
  parameter int unsigned OUTW        = 16,
  parameter int unsigned SLICEW      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1
);

  logic signed [ACCUM_DATAW-1:0] i_ofifo_data [0:NUM_SLICES-1][0:BATCH-1];
  logic        [NUM_SLICES-1:0]  i_ofifo_ready;
  logic        [NUM_SLICES-1:0]  o_ofifo_ren;
  logic signed [OUTW-1:0]        o_res_data;
  logic        [SLICEW-1:0]      o_res_slice;
  logic                          o_res_last;
  logic                          o_res_valid;
  logic                          i_res_ready;

  modport master (
    input  i_ofifo_data, i_ofifo_ready, i_res_ready,
    output o_ofifo_ren, o_res_data, o_res_slice, o_res_last, o_res_valid
  );

  modport slave (
    output i_ofifo_data, i_ofifo_ready, i_res_ready,
    input  o_ofifo_ren, o_res_data, o_res_slice, o_res_last, o_res_valid
  );

endinterface

// File: rtl/npu_ofifo_collector_rr_arbiter.sv
// ----------------------------------------------------------------------------
// npu_rr_arbiter
// Combinational round-robin arbiter. Searches req_i starting at ptr_i and
// wrapping; the first requester found wins.
//   req_i       : request vector, bit k = requester k
//   ptr_i       : highest-priority requester index
//   gnt_o       : one-hot grant (zero when no request)
//   gnt_idx_o   : index of the granted requester
//   gnt_valid_o : any request granted
// ----------------------------------------------------------------------------
module npu_rr_arbiter #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] gnt_idx_o,
  output logic          gnt_valid_o
);

  logic [IW-1:0] cand;
  logic          found;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    found       = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      cand = IW'((32'(ptr_i) + k) % N);
      if (!found && req_i[cand]) begin
        found       = 1'b1;
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/npu_ofifo_collector.sv
// ----------------------------------------------------------------------------
// npu_ofifo_collector
// Drains the per-slice output FIFOs of the NPU slice array and serializes
// each BATCH-wide entry into one element per handshake, tagged with the
// source slice and a last flag. Slices are picked round-robin.
//   clk : clock, rising edge
//   rst : synchronous active-high reset
//   bus : npu_ofifo_collector_if.master (FIFO read side + result stream)
// Build option: define NPU_COLLECTOR_SAT_EN to saturate each element from
// ACCUM_DATAW to RES_DATAW at capture (result width RES_DATAW instead of
// ACCUM_DATAW).
// ----------------------------------------------------------------------------
module npu_ofifo_collector
  import npu_ofifo_collector_pkg::*;
#(
  parameter int unsigned NUM_SLICES  = 4,
  parameter int unsigned BATCH       = 3,
  parameter int unsigned ACCUM_DATAW = 16,
  parameter int unsigned RES_DATAW   = 8
) (
  input logic                    clk,
  input logic                    rst,
  npu_ofifo_collector_if.master  bus
);

  localparam int unsigned SLICEW = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;
  localparam int unsigned IDXW   = (BATCH > 1) ? $clog2(BATCH) : 1;
`ifdef NPU_COLLECTOR_SAT_EN
  localparam int unsigned OUTW   = RES_DATAW;
`else
  localparam int unsigned OUTW   = ACCUM_DATAW;
`endif

  function automatic logic signed [OUTW-1:0] conv_elem(input logic signed [ACCUM_DATAW-1:0] v);
`ifdef NPU_COLLECTOR_SAT_EN
    return OUTW'(sat_signed(64'(v), RES_DATAW));
`else
    return v;
`endif
  endfunction

  coll_state_e            state_q;
  logic [SLICEW-1:0]      ptr_q;
  logic [SLICEW-1:0]      tag_q;
  logic [IDXW-1:0]        idx_q;
  logic signed [OUTW-1:0] buf_q [0:BATCH-1];
  logic signed [OUTW-1:0] data_q;
  logic                   valid_q;

  logic [NUM_SLICES-1:0]  gnt;
  logic [SLICEW-1:0]      gnt_idx;
  logic                   gnt_valid;
  logic                   is_last;

  npu_rr_arbiter #(
    .N  (NUM_SLICES),
    .IW (SLICEW)
  ) u_arb (
    .req_i       (bus.i_ofifo_ready),
    .ptr_i       (ptr_q),
    .gnt_o       (gnt),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  assign is_last = (state_q == SEND) && (idx_q == IDXW'(BATCH - 1));

  // Pop in the same cycle the grant is made; the entry is captured at the edge.
  assign bus.o_ofifo_ren = (state_q == ARB && !rst) ? gnt : '0;
  assign bus.o_res_data  = data_q;
  assign bus.o_res_slice = tag_q;
  assign bus.o_res_last  = is_last;
  assign bus.o_res_valid = valid_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ARB;
      ptr_q   <= '0;
      tag_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      unique case (state_q)
        ARB: begin
          if (gnt_valid) begin
            for (int unsigned i = 0; i < BATCH; i++) begin
              buf_q[i] <= conv_elem(bus.i_ofifo_data[gnt_idx][i]);
            end
            // Element 0 goes straight to the output register so valid data
            // appears one cycle after the pop.
            data_q  <= conv_elem(bus.i_ofifo_data[gnt_idx][0]);
            tag_q   <= gnt_idx;
            idx_q   <= '0;
            ptr_q   <= (gnt_idx == SLICEW'(NUM_SLICES - 1)) ? '0 : gnt_idx + 1'b1;
            valid_q <= 1'b1;
            state_q <= SEND;
          end
        end
        SEND: begin
          if (bus.i_res_ready) begin
            if (is_last) begin
              valid_q <= 1'b0;
              state_q <= ARB;
            end else begin
              idx_q  <= idx_q + 1'b1;
              data_q <= buf_q[idx_q + 1'b1];
            end
          end
        end
        default: state_q <= ARB;
      endcase
    end
  end

endmodule

// File: tb/tb_npu_ofifo_collector.sv
// ----------------------------------------------------------------------------
// tb_npu_ofifo_collector
// Directed bench for npu_ofifo_collector: a 4-slice/BATCH=3 instance and a
// 2-slice/BATCH=1 instance sharing clock and reset.
// ----------------------------------------------------------------------------
module tb_npu_ofifo_collector;

`ifdef NPU_COLLECTOR_SAT_EN
  localparam int unsigned OUTW = 8;
`else
  localparam int unsigned OUTW = 16;
`endif

  logic clk;
  logic rst;
  int   n_checks;
  int   n_errors;

  npu_ofifo_collector_if #(.NUM_SLICES(4), .BATCH(3), .ACCUM_DATAW(16), .OUTW(OUTW)) bus0 ();
  npu_ofifo_collector_if #(.NUM_SLICES(2), .BATCH(1), .ACCUM_DATAW(16), .OUTW(OUTW)) bus1 ();

  npu_ofifo_collector #(.NUM_SLICES(4), .BATCH(3), .ACCUM_DATAW(16), .RES_DATAW(8)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  npu_ofifo_collector #(.NUM_SLICES(2), .BATCH(1), .ACCUM_DATAW(16), .RES_DATAW(8)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  task automatic set_entry(input int s, input int a, input int b, input int c);
    bus0.i_ofifo_data[s][0] = 16'(a);
    bus0.i_ofifo_data[s][1] = 16'(b);
    bus0.i_ofifo_data[s][2] = 16'(c);
  endtask

  task automatic chk_out(input string tag, input int d, input int s, input int l);
    check({tag, "_valid"}, bus0.o_res_valid, 1);
    check({tag, "_data"},  bus0.o_res_data,  d);
    check({tag, "_slice"}, bus0.o_res_slice, s);
    check({tag, "_last"},  bus0.o_res_last,  l);
  endtask

  int gcyc [0:4];
  int gidx [0:4];
  int ng;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1;
    for (int s = 0; s < 4; s++) set_entry(s, 0, 0, 0);
    bus0.i_ofifo_ready = 4'hF;
    bus0.i_res_ready   = 1'b1;
    bus1.i_ofifo_data[0][0] = 16'sd100;
    bus1.i_ofifo_data[1][0] = 16'sd200;
    bus1.i_ofifo_ready = 2'b00;
    bus1.i_res_ready   = 1'b1;

    // Reset state; ren stays low while rst is high even with slices ready.
    cyc(); cyc(); settle();
    check("rst_ren",   bus0.o_ofifo_ren, 0);
    check("rst_valid", bus0.o_res_valid, 0);
    check("rst_data",  bus0.o_res_data,  0);
    check("rst_slice", bus0.o_res_slice, 0);
    check("rst_last",  bus0.o_res_last,  0);

    // Single slice, continuous ready.
    bus0.i_ofifo_ready = 4'b0000;
    set_entry(2, 5, -7, 9);
    rst = 1'b0;
    bus0.i_ofifo_ready = 4'b0100;
    settle();
    check("t1_ren", bus0.o_ofifo_ren, 4'b0100);
    cyc(); bus0.i_ofifo_ready = 4'b0000; settle();
    chk_out("t1_e0", 5, 2, 0);
    check("t1_ren_e0", bus0.o_ofifo_ren, 0);
    cyc(); settle();
    chk_out("t1_e1", -7, 2, 0);
    cyc(); settle();
    chk_out("t1_e2", 9, 2, 1);
    cyc(); settle();
    check("t1_idle_valid", bus0.o_res_valid, 0);
    check("t1_idle_ren",   bus0.o_ofifo_ren, 0);
    check("t1_idle_last",  bus0.o_res_last,  0);

    // Round-robin fairness with all slices ready.
    do_reset();
    for (int s = 0; s < 4; s++) set_entry(s, 10 * s, 10 * s + 1, 10 * s + 2);
    bus0.i_ofifo_ready = 4'hF;
    settle();
    ng = 0;
    for (int c = 0; c < 40 && ng < 5; c++) begin
      if (bus0.o_ofifo_ren != 4'b0000) begin
        check("t2_onehot", $countones(bus0.o_ofifo_ren), 1);
        gcyc[ng] = c;
        for (int b = 0; b < 4; b++) if (bus0.o_ofifo_ren[b]) gidx[ng] = b;
        ng++;
      end
      cyc(); settle();
    end
    check("t2_ngrants", ng, 5);
    for (int k = 0; k < 5; k++) begin
      if (k < ng) begin
        check("t2_order", gidx[k], k % 4);
        if (k > 0) check("t2_spacing", gcyc[k] - gcyc[k-1], 4);
      end
    end

    // Backpressure at element 1.
    do_reset();
    bus0.i_ofifo_ready = 4'b0000;
    set_entry(1, 11, 22, 33);
    set_entry(0, 44, 55, 66);
    bus0.i_ofifo_ready = 4'b0010;
    settle();
    check("t3_ren", bus0.o_ofifo_ren, 4'b0010);
    cyc(); bus0.i_ofifo_ready = 4'b0000; settle();
    chk_out("t3_e0", 11, 1, 0);
    cyc(); bus0.i_res_ready = 1'b0; bus0.i_ofifo_ready = 4'b0001; settle();
    chk_out("t3_e1", 22, 1, 0);
    for (int k = 0; k < 5; k++) begin
      cyc(); settle();
      chk_out("t3_hold", 22, 1, 0);
      check("t3_hold_ren", bus0.o_ofifo_ren, 0);
    end
    bus0.i_res_ready = 1'b1;
    cyc(); settle();
    chk_out("t3_e2", 33, 1, 1);
    cyc(); settle();
    check("t3_arb_valid", bus0.o_res_valid, 0);
    check("t3_arb_ren",   bus0.o_ofifo_ren, 4'b0001);

    // Reset mid-SEND at idx=1.
    do_reset();
    bus0.i_ofifo_ready = 4'b0000;
    set_entry(2, 1, 2, 3);
    set_entry(1, 7, 8, 9);
    bus0.i_ofifo_ready = 4'b0100;
    cyc(); bus0.i_ofifo_ready = 4'b0000;
    cyc(); settle();
    chk_out("t4_e1", 2, 2, 0);
    rst = 1'b1;
    bus0.i_ofifo_ready = 4'b1010;
    settle();
    check("t4_rst_ren", bus0.o_ofifo_ren, 0);
    cyc(); rst = 1'b0; settle();
    check("t4_valid", bus0.o_res_valid, 0);
    check("t4_data",  bus0.o_res_data,  0);
    check("t4_slice", bus0.o_res_slice, 0);
    check("t4_last",  bus0.o_res_last,  0);
    check("t4_ren",   bus0.o_ofifo_ren, 4'b0010);
    cyc(); bus0.i_ofifo_ready = 4'b0000; settle();
    chk_out("t4_first", 7, 1, 0);

    // Wide values: saturated or passed through depending on the build.
    do_reset();
    bus0.i_ofifo_ready = 4'b0000;
    set_entry(0, 300, -300, -128);
    bus0.i_ofifo_ready = 4'b0001;
    cyc(); bus0.i_ofifo_ready = 4'b0000; settle();
`ifdef NPU_COLLECTOR_SAT_EN
    chk_out("t5_e0", 127, 0, 0);
    cyc(); settle();
    chk_out("t5_e1", -128, 0, 0);
`else
    chk_out("t5_e0", 300, 0, 0);
    cyc(); settle();
    chk_out("t5_e1", -300, 0, 0);
`endif
    cyc(); settle();
    chk_out("t5_e2", -128, 0, 1);

    // BATCH=1 instance: ren and valid alternate, every element is last.
    do_reset();
    bus1.i_ofifo_ready = 2'b11;
    settle();
    for (int k = 0; k < 8; k++) begin
      if (k % 2 == 0) begin
        check("t6_ren",   bus1.o_ofifo_ren, ((k / 2) % 2 == 0) ? 2'b01 : 2'b10);
        check("t6_valid", bus1.o_res_valid, 0);
      end else begin
        check("t6_ren",   bus1.o_ofifo_ren, 0);
        check("t6_valid", bus1.o_res_valid, 1);
        check("t6_last",  bus1.o_res_last,  1);
        check("t6_slice", bus1.o_res_slice, ((k - 1) / 2) % 2);
        check("t6_data",  bus1.o_res_data,  (((k - 1) / 2) % 2 == 0) ? 100 : 200);
      end
      cyc(); settle();
    end
    bus1.i_ofifo_ready = 2'b00;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
